apb_requester: RTL and testbench

- APB initiator that converts a simple valid/ready command into one APB transfer and returns a one-cycle response.
- Drives the same APB signal set that apb_uart_top responds to.
- Reused as the CPU-side bridge in integration tops, and as a known-good master in benches.
- Adds a bounded wait-state timeout so a hung completer cannot stall the requester.

---
 rtl/apb_requester_if.sv | 43 ++++
 rtl/apb_requester.sv | 143 ++++++++++++++
 tb/tb_apb_requester.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_requester_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_requester_if
//  Purpose  : Command/response and APB bus bundle for apb_requester.
//  Revision : 1.0
// ============================================================================
interface apb_requester_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    // Requester view
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    // Environment view: command source plus APB completer
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface
`default_nettype wire

// File: rtl/apb_requester.sv
`default_nettype none
// ============================================================================
//  Module   : apb_requester
//  Purpose  : Turns one valid/ready command into one APB transfer and returns
//             a single-cycle response, with an optional wait-state timeout.
//  Revision : 1.0
// ============================================================================
module apb_requester #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire             PCLK,
    input  wire             PRESETn,
    apb_requester_if.master bus
);

    localparam int         c_CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_cmd_ready,   w_cmd_ready;
    logic                  r_psel,        w_psel;
    logic                  r_penable,     w_penable;
    logic                  r_pwrite,      w_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr,       w_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata,      w_pwdata;
    logic                  r_rsp_valid,   w_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata,   w_rsp_rdata;
    logic                  r_rsp_err,     w_rsp_err;
    logic                  r_rsp_timeout, w_rsp_timeout;
    logic [c_CNT_W-1:0]    r_wait_cnt,    w_wait_cnt;
    logic                  w_accept;
    logic                  w_expire;

    assign w_accept = (r_state == c_IDLE) && r_cmd_ready && bus.cmd_valid;

    // Expiry fires on the edge that would complete the TIMEOUT_CYCLES-th idle wait.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
            assign w_expire = !bus.PREADY && (r_wait_cnt == c_TO_LAST);
        end else begin : g_no_timeout
            assign w_expire = 1'b0;
        end
    endgenerate

    // State and registered outputs
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state       <= c_IDLE;
            r_cmd_ready   <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_wait_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cmd_ready   <= w_cmd_ready;
            r_psel        <= w_psel;
            r_penable     <= w_penable;
            r_pwrite      <= w_pwrite;
            r_paddr       <= w_paddr;
            r_pwdata      <= w_pwdata;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_err     <= w_rsp_err;
            r_rsp_timeout <= w_rsp_timeout;
            r_wait_cnt    <= w_wait_cnt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_accept) w_state_nxt = c_SETUP;
            c_SETUP:  w_state_nxt = c_ACCESS;
            c_ACCESS: if (bus.PREADY || w_expire) w_state_nxt = c_RESP;
            c_RESP:   w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    // Next values of every registered output, derived from the upcoming state
    always_comb begin
        w_cmd_ready   = (w_state_nxt == c_IDLE);
        w_psel        = (w_state_nxt == c_SETUP) || (w_state_nxt == c_ACCESS);
        w_penable     = (w_state_nxt == c_ACCESS);
        w_rsp_valid   = (w_state_nxt == c_RESP);
        w_pwrite      = r_pwrite;
        w_paddr       = r_paddr;
        w_pwdata      = r_pwdata;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_err     = r_rsp_err;
        w_rsp_timeout = r_rsp_timeout;
        w_wait_cnt    = r_wait_cnt;

        if (w_accept) begin
            w_pwrite   = bus.cmd_write;
            w_paddr    = bus.cmd_addr;
            w_pwdata   = bus.cmd_wdata;
            w_wait_cnt = '0;
        end

        if (r_state == c_ACCESS) begin
            if (bus.PREADY) begin
                w_rsp_rdata   = r_pwrite ? '0 : bus.PRDATA;
                w_rsp_err     = bus.PSLVERR;
                w_rsp_timeout = 1'b0;
            end else begin
                w_wait_cnt = r_wait_cnt + c_CNT_W'(1);
                if (w_expire) begin
                    w_rsp_rdata   = '0;
                    w_rsp_err     = 1'b1;
                    w_rsp_timeout = 1'b1;
                end
            end
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.PSELx       = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb_requester.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_requester
//  Purpose  : Self-checking bench for apb_requester with a behavioural completer.
//  Revision : 1.0
// ============================================================================
module tb_apb_requester;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic pclk    = 1'b0;
    logic presetn = 1'b0;
    always #5 pclk = ~pclk;

    apb_requester_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    apb_requester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK    (pclk),
        .PRESETn (presetn),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of one transfer
    int          ob_setup, ob_acc, ob_rcyc, ob_rsp_n, ob_bad;
    logic [31:0] ob_rdata;
    logic        ob_err, ob_to, ob_ready, ob_kept;

    // Expected outcome of one transfer
    int          ex_acc;
    logic [31:0] ex_rdata;
    logic        ex_err, ex_to;

    // A completer stalling nwait cycles either answers on cycle nwait+1, or the
    // requester gives up after TO stalled cycles, whichever comes first.
    task automatic model_xfer(input logic wr, input int nwait, input logic [31:0] rd, input logic err);
        if (TO > 0 && nwait >= TO) begin
            ex_acc = TO;  ex_rdata = 32'h0;  ex_err = 1'b1;  ex_to = 1'b1;
        end else begin
            ex_acc = nwait + 1;  ex_rdata = wr ? 32'h0 : rd;  ex_err = err;  ex_to = 1'b0;
        end
    endtask

    task automatic drive_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input int nwait, input logic [31:0] rd, input logic err);
        int g;
        ob_setup = 0; ob_acc = 0; ob_rcyc = -1; ob_rsp_n = 0; ob_bad = 0;
        ob_rdata = 32'hx; ob_err = 1'bx; ob_to = 1'bx; ob_ready = 1'b0; ob_kept = 1'b0;
        @(negedge pclk);
        bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata; bus.cmd_valid = 1'b1;
        g = 0;
        while (!bus.cmd_ready && g < 20) begin
            @(negedge pclk);
            g++;
        end
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge pclk);
            if (cyc == 1) bus.cmd_valid = 1'b0;
            if (bus.PSELx && (bus.PADDR !== addr || bus.PWRITE !== wr || bus.PWDATA !== wdata)) ob_bad++;
            if (bus.PSELx && !bus.PENABLE) ob_setup++;
            if (bus.PSELx && bus.PENABLE) begin
                ob_acc++;
                if (ob_acc == nwait + 1) begin
                    bus.PREADY = 1'b1; bus.PRDATA = rd; bus.PSLVERR = err;
                end else begin
                    bus.PREADY = 1'b0; bus.PRDATA = $urandom; bus.PSLVERR = 1'($urandom);
                end
            end else begin
                bus.PREADY = 1'b0; bus.PRDATA = $urandom; bus.PSLVERR = 1'b0;
            end
            if (bus.rsp_valid) begin
                ob_rsp_n++;
                if (ob_rcyc < 0) begin
                    ob_rcyc = cyc; ob_rdata = bus.rsp_rdata; ob_err = bus.rsp_err; ob_to = bus.rsp_timeout;
                end
            end
            if (ob_rcyc > 0 && cyc == ob_rcyc + 1) begin
                ob_ready = bus.cmd_ready;
                ob_kept  = (bus.PADDR === addr) && (bus.PWDATA === wdata) && (bus.PWRITE === wr);
                break;
            end
        end
        bus.PREADY = 1'b0;
        bus.PSLVERR = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.PSELx, bus.PENABLE, bus.PWRITE} !== 7'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b required 0000000",
                {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.PSELx, bus.PENABLE, bus.PWRITE});
        end
        n_checks++;
        if ((bus.PADDR | bus.PWDATA | bus.rsp_rdata) !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h/%h required 0", bus.PADDR, bus.PWDATA, bus.rsp_rdata);
        end
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        #1;
        n_checks++;
        if (bus.cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_before_edge: got %b required 0", bus.cmd_ready);
        end
        @(negedge pclk);
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_first_edge: got %b required 1", bus.cmd_ready);
        end
    endtask

    task automatic test_write_zero_wait();
        drive_xfer(1'b1, 32'h0000_0004, 32'hA5A5_1234, 0, 32'h1357_9BDF, 1'b0);
        model_xfer(1'b1, 0, 32'h1357_9BDF, 1'b0);
        n_checks++;
        if (ob_setup !== 1 || ob_acc !== ex_acc) begin
            n_fail++; $display("FAIL wr0_phases: got setup=%0d access=%0d required 1/%0d", ob_setup, ob_acc, ex_acc);
        end
        n_checks++;
        if (ob_rcyc !== 2 + ex_acc) begin
            n_fail++; $display("FAIL wr0_latency: got %0d required %0d", ob_rcyc, 2 + ex_acc);
        end
        n_checks++;
        if (ob_rdata !== ex_rdata || ob_err !== ex_err || ob_to !== ex_to) begin
            n_fail++; $display("FAIL wr0_rsp: got %h/%b/%b required %h/%b/%b", ob_rdata, ob_err, ob_to, ex_rdata, ex_err, ex_to);
        end
        n_checks++;
        if (ob_rsp_n !== 1 || ob_ready !== 1'b1 || ob_kept !== 1'b1 || ob_bad !== 0) begin
            n_fail++; $display("FAIL wr0_after: got rsp_n=%0d ready=%b kept=%b bad=%0d required 1/1/1/0", ob_rsp_n, ob_ready, ob_kept, ob_bad);
        end
    endtask

    task automatic test_read_wait();
        drive_xfer(1'b0, 32'h0000_0008, 32'h0BAD_F00D, 3, 32'hDEAD_BEEF, 1'b0);
        model_xfer(1'b0, 3, 32'hDEAD_BEEF, 1'b0);
        n_checks++;
        if (ob_acc !== ex_acc || ob_bad !== 0) begin
            n_fail++; $display("FAIL rd3_access: got access=%0d unstable=%0d required %0d/0", ob_acc, ob_bad, ex_acc);
        end
        n_checks++;
        if (ob_rcyc !== 2 + ex_acc) begin
            n_fail++; $display("FAIL rd3_latency: got %0d required %0d", ob_rcyc, 2 + ex_acc);
        end
        n_checks++;
        if (ob_rdata !== ex_rdata || ob_err !== ex_err) begin
            n_fail++; $display("FAIL rd3_rsp: got %h/%b required %h/%b", ob_rdata, ob_err, ex_rdata, ex_err);
        end
    endtask

    task automatic test_slave_error();
        logic [31:0] rd;
        rd = $urandom;
        drive_xfer(1'b0, 32'h0000_000C, 32'h0, 0, rd, 1'b1);
        n_checks++;
        if (ob_err !== 1'b1 || ob_to !== 1'b0 || ob_rdata !== rd) begin
            n_fail++; $display("FAIL slverr_rsp: got err=%b to=%b rdata=%h required 1/0/%h", ob_err, ob_to, ob_rdata, rd);
        end
        rd = $urandom;
        drive_xfer(1'b0, 32'h0000_000C, 32'h0, 3, rd, 1'b0);
        n_checks++;
        if (ob_err !== 1'b0 || ob_to !== 1'b0 || ob_rdata !== rd) begin
            n_fail++; $display("FAIL slverr_ignored_while_waiting: got err=%b to=%b rdata=%h required 0/0/%h", ob_err, ob_to, ob_rdata, rd);
        end
    endtask

    task automatic test_timeout();
        drive_xfer(1'b0, 32'h0000_0010, 32'h0, 40, 32'h1111_2222, 1'b0);
        model_xfer(1'b0, 40, 32'h1111_2222, 1'b0);
        n_checks++;
        if (ob_acc !== ex_acc || ob_rcyc !== 2 + ex_acc) begin
            n_fail++; $display("FAIL timeout_cycles: got access=%0d rsp_at=%0d required %0d/%0d", ob_acc, ob_rcyc, ex_acc, 2 + ex_acc);
        end
        n_checks++;
        if (ob_err !== 1'b1 || ob_to !== 1'b1 || ob_rdata !== 32'h0 || ob_rsp_n !== 1) begin
            n_fail++; $display("FAIL timeout_rsp: got err=%b to=%b rdata=%h n=%0d required 1/1/0/1", ob_err, ob_to, ob_rdata, ob_rsp_n);
        end
        drive_xfer(1'b0, 32'h0000_0014, 32'h0, TO - 1, 32'h3333_4444, 1'b0);
        model_xfer(1'b0, TO - 1, 32'h3333_4444, 1'b0);
        n_checks++;
        if (ob_acc !== ex_acc || ob_to !== 1'b0 || ob_err !== 1'b0 || ob_rdata !== ex_rdata) begin
            n_fail++; $display("FAIL timeout_ready_wins: got access=%0d to=%b err=%b rdata=%h required %0d/0/0/%h",
                ob_acc, ob_to, ob_err, ob_rdata, ex_acc, ex_rdata);
        end
    endtask

    task automatic test_random();
        logic        wr, err;
        logic [31:0] addr, wdata, rd;
        int          nwait;
        for (int i = 0; i < 16; i++) begin
            wr = 1'($urandom); err = 1'($urandom);
            addr = $urandom; wdata = $urandom; rd = $urandom;
            nwait = $urandom_range(0, 20);
            drive_xfer(wr, addr, wdata, nwait, rd, err);
            model_xfer(wr, nwait, rd, err);
            n_checks++;
            if (ob_setup !== 1 || ob_acc !== ex_acc || ob_rcyc !== 2 + ex_acc || ob_rsp_n !== 1) begin
                n_fail++; $display("FAIL rand%0d_timing: got setup=%0d access=%0d rsp_at=%0d n=%0d required 1/%0d/%0d/1",
                    i, ob_setup, ob_acc, ob_rcyc, ob_rsp_n, ex_acc, 2 + ex_acc);
            end
            n_checks++;
            if (ob_rdata !== ex_rdata || ob_err !== ex_err || ob_to !== ex_to) begin
                n_fail++; $display("FAIL rand%0d_rsp: got %h/%b/%b required %h/%b/%b", i, ob_rdata, ob_err, ob_to, ex_rdata, ex_err, ex_to);
            end
            n_checks++;
            if (ob_bad !== 0 || ob_kept !== 1'b1 || ob_ready !== 1'b1) begin
                n_fail++; $display("FAIL rand%0d_bus: got unstable=%0d kept=%b ready=%b required 0/1/1", i, ob_bad, ob_kept, ob_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] adr [4];
        int          acc_at [4];
        int          n_acc, n_rsp, bad, gap_bad;
        bit          took;
        n_acc = 0; n_rsp = 0; bad = 0; gap_bad = 0;
        for (int i = 0; i < 4; i++) begin
            adr[i] = $urandom;
            acc_at[i] = 0;
        end
        @(negedge pclk);
        bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
        bus.cmd_write = 1'b1; bus.cmd_addr = adr[0]; bus.cmd_wdata = ~adr[0]; bus.cmd_valid = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            took = 1'b0;
            if (bus.PSELx && (n_acc == 0 || n_acc > 4 || bus.PADDR !== adr[n_acc-1])) bad++;
            if (bus.rsp_valid) n_rsp++;
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (n_acc < 4) acc_at[n_acc] = cyc;
                n_acc++;
                took = 1'b1;
            end
            @(posedge pclk);
            #1;
            if (took) begin
                if (n_acc < 4) begin
                    bus.cmd_addr = adr[n_acc]; bus.cmd_wdata = ~adr[n_acc];
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
            @(negedge pclk);
        end
        bus.PREADY = 1'b0;
        for (int i = 1; i < 4; i++) if (acc_at[i] - acc_at[i-1] != 4) gap_bad++;
        n_checks++;
        if (n_acc !== 4 || n_rsp !== 4) begin
            n_fail++; $display("FAIL b2b_counts: got accepts=%0d responses=%0d required 4/4", n_acc, n_rsp);
        end
        n_checks++;
        if (gap_bad !== 0) begin
            n_fail++; $display("FAIL b2b_spacing: got accepts at %0d,%0d,%0d,%0d required 4 apart", acc_at[0], acc_at[1], acc_at[2], acc_at[3]);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL b2b_paddr: got %0d wrong-address cycles required 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int g;
        bit seen_rsp;
        @(negedge pclk);
        bus.PREADY = 1'b0;
        bus.cmd_write = 1'b1; bus.cmd_addr = 32'h0000_0020; bus.cmd_wdata = 32'hCAFE_0001; bus.cmd_valid = 1'b1;
        g = 0;
        while (!(bus.PSELx && bus.PENABLE) && g < 20) begin
            @(negedge pclk);
            g++;
            if (!bus.cmd_ready) bus.cmd_valid = 1'b0;
        end
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (!(bus.PSELx && bus.PENABLE)) begin
            n_fail++; $display("FAIL rstmid_reach_access: got psel=%b penable=%b required 1/1", bus.PSELx, bus.PENABLE);
        end
        #2 presetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.PSELx, bus.PENABLE, bus.PWRITE} !== 5'b0 || (bus.PADDR | bus.PWDATA) !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_outputs: got flags=%b paddr=%h pwdata=%h required 0",
                {bus.cmd_ready, bus.rsp_valid, bus.PSELx, bus.PENABLE, bus.PWRITE}, bus.PADDR, bus.PWDATA);
        end
        seen_rsp = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            if (bus.rsp_valid) seen_rsp = 1'b1;
        end
        bus.PREADY = 1'b1;
        presetn = 1'b1;
        #1;
        n_checks++;
        if (bus.cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_ready_before_edge: got %b required 0", bus.cmd_ready);
        end
        @(negedge pclk);
        if (bus.rsp_valid) seen_rsp = 1'b1;
        bus.PREADY = 1'b0;
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.PSELx !== 1'b0 || seen_rsp) begin
            n_fail++; $display("FAIL rstmid_recovery: got ready=%b psel=%b rsp_seen=%b required 1/0/0", bus.cmd_ready, bus.PSELx, seen_rsp);
        end
        drive_xfer(1'b0, 32'h0000_0024, 32'h0, TO - 1, 32'h5A5A_A5A5, 1'b0);
        n_checks++;
        if (ob_acc !== TO || ob_to !== 1'b0 || ob_rdata !== 32'h5A5A_A5A5) begin
            n_fail++; $display("FAIL rstmid_clean_counter: got access=%0d to=%b rdata=%h required %0d/0/5a5aa5a5", ob_acc, ob_to, ob_rdata, TO);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slave_error();
        test_timeout();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
